// File: rtl/uart_pkg.sv
// Shared definitions for the UART bus bridge: register map, STATUS bit layout
// and FSM state encodings.
package uart_pkg;

    localparam logic ADDR_DATA   = 1'b0;
    localparam logic ADDR_STATUS = 1'b1;

    localparam int ST_TX_EMPTY    = 0;
    localparam int ST_TX_FULL     = 1;
    localparam int ST_RX_VALID    = 2;
    localparam int ST_RX_OVERRUN  = 3;
    localparam int ST_TX_OVERFLOW = 4;

    typedef enum logic [1:0] {
        T_IDLE,
        T_BUSY,
        T_DONE
    } tx_state_t;

    typedef enum logic {
        R_IDLE,
        R_ACK
    } rx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Show-ahead byte FIFO: rdata always presents the head entry combinationally.
// Push into a full FIFO and pop from an empty one are ignored.
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       empty,
    output logic       full
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_bridge.sv
// Memory-mapped DATA/STATUS front end for the UART: TX and RX byte FIFOs with
// handshake FSMs toward the UART's parallel ports.
module uart_bridge
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic       we,
    input  logic       addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       irq,
    output logic       uart_we,
    output logic [7:0] uart_din,
    input  logic       uart_empty,
    output logic       uart_re,
    input  logic       uart_full,
    input  logic [7:0] uart_dout
);

    logic       rd_data, rd_status, wr_data;
    logic       tx_pop, tx_empty, tx_full;
    logic [7:0] tx_rdata;
    logic       rx_push, rx_empty, rx_full;
    logic [7:0] rx_rdata;
    logic       tx_overflow, rx_overrun;
    logic       ovf_set, ovr_set;
    logic [7:0] status;

    tx_state_t tx_state, tx_state_nxt;
    rx_state_t rx_state, rx_state_nxt;

    assign rd_data   = cs & ~we & (addr == ADDR_DATA);
    assign rd_status = cs & ~we & (addr == ADDR_STATUS);
    assign wr_data   = cs &  we & (addr == ADDR_DATA);
    assign ovf_set   = wr_data & tx_full;
    assign irq       = ~rx_empty;

    byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_data),
        .pop   (tx_pop),
        .wdata (din),
        .rdata (tx_rdata),
        .empty (tx_empty),
        .full  (tx_full)
    );

    byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rd_data),
        .wdata (uart_dout),
        .rdata (rx_rdata),
        .empty (rx_empty),
        .full  (rx_full)
    );

    always_comb begin
        status                 = 8'h00;
        status[ST_TX_EMPTY]    = tx_empty;
        status[ST_TX_FULL]     = tx_full;
        status[ST_RX_VALID]    = ~rx_empty;
        status[ST_RX_OVERRUN]  = rx_overrun;
        status[ST_TX_OVERFLOW] = tx_overflow;
    end

    // STATUS read returns the pre-cycle flags; a same-cycle set wins over the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout        <= 8'h00;
            tx_overflow <= 1'b0;
            rx_overrun  <= 1'b0;
        end else begin
            if (rd_data)        dout <= rx_empty ? 8'h00 : rx_rdata;
            else if (rd_status) dout <= status;

            if (ovf_set)        tx_overflow <= 1'b1;
            else if (rd_status) tx_overflow <= 1'b0;

            if (ovr_set)        rx_overrun <= 1'b1;
            else if (rd_status) rx_overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= T_IDLE;
            rx_state <= R_IDLE;
        end else begin
            tx_state <= tx_state_nxt;
            rx_state <= rx_state_nxt;
        end
    end

    always_comb begin
        tx_state_nxt = tx_state;
        uart_we      = 1'b0;
        tx_pop       = 1'b0;
        case (tx_state)
            T_IDLE: if (!tx_empty && uart_empty) begin
                uart_we      = 1'b1;
                tx_pop       = 1'b1;
                tx_state_nxt = T_BUSY;
            end
            T_BUSY: if (!uart_empty) tx_state_nxt = T_DONE;
            T_DONE: if (uart_empty)  tx_state_nxt = T_IDLE;
            default: tx_state_nxt = T_IDLE;
        endcase
    end

    assign uart_din = uart_we ? tx_rdata : 8'h00;

    // With the RX FIFO full the UART keeps its byte; only the overrun flag records it.
    always_comb begin
        rx_state_nxt = rx_state;
        uart_re      = 1'b0;
        rx_push      = 1'b0;
        ovr_set      = 1'b0;
        case (rx_state)
            R_IDLE: if (uart_full) begin
                if (!rx_full) begin
                    uart_re      = 1'b1;
                    rx_push      = 1'b1;
                    rx_state_nxt = R_ACK;
                end else begin
                    ovr_set = 1'b1;
                end
            end
            R_ACK:   rx_state_nxt = R_IDLE;
            default: rx_state_nxt = R_IDLE;
        endcase
    end

endmodule
